// File: rtl/lcd_temp_drv.sv
// ============================================================================
// Module   : lcd_temp_drv
// Purpose  : 4-digit multiplexed 7-segment driver for a BCD temperature C DU.d
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_temp_drv #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       centena,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  input  logic [3:0] decimos,
  output logic [7:0] seg,
  output logic [3:0] dig,
  output logic       frame_start,
  output logic       pending
);

  localparam int             CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  c_last  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  c_blank = CW'(BLANK_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_slot;
  logic          r_act_c, r_pnd_c;
  logic [3:0]    r_act_d, r_act_u, r_act_t;
  logic [3:0]    r_pnd_d, r_pnd_u, r_pnd_t;
  logic          r_pending;
  logic [7:0]    r_seg;
  logic [3:0]    r_dig;
  logic          r_fs;

  logic          w_wrap, w_boundary, w_lz;
  logic [3:0]    w_val;
  logic [7:0]    w_seg_nxt;
  logic [3:0]    w_dig_nxt;
  logic          w_fs_nxt;

  // Active-low gfedcba; out-of-range BCD renders as a dash.
  function automatic logic [6:0] f_seg7(input logic [3:0] v);
    case (v)
      4'd0:    f_seg7 = 7'b1000000;
      4'd1:    f_seg7 = 7'b1111001;
      4'd2:    f_seg7 = 7'b0100100;
      4'd3:    f_seg7 = 7'b0110000;
      4'd4:    f_seg7 = 7'b0011001;
      4'd5:    f_seg7 = 7'b0010010;
      4'd6:    f_seg7 = 7'b0000010;
      4'd7:    f_seg7 = 7'b1111000;
      4'd8:    f_seg7 = 7'b0000000;
      4'd9:    f_seg7 = 7'b0010000;
      default: f_seg7 = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    w_wrap     = (r_cnt == c_last);
    w_boundary = w_wrap && (r_slot == 2'd3);
    w_fs_nxt   = (r_slot == 2'd0) && (r_cnt == '0);
    case (r_slot)
      2'd0:    w_val = r_act_t;
      2'd1:    w_val = r_act_u;
      2'd2:    w_val = r_act_d;
      default: w_val = {3'b000, r_act_c};
    endcase
    w_lz = LZ_BLANK && !r_act_c &&
           ((r_slot == 2'd3) || ((r_slot == 2'd2) && (r_act_d == 4'd0)));
    w_seg_nxt = 8'hFF;
    w_dig_nxt = 4'hF;
    if (r_cnt >= c_blank) begin
      w_dig_nxt = ~(4'b0001 << r_slot);
      // Blanked leading zeros keep the digit enabled so duty stays uniform.
      if (!w_lz) begin
        w_seg_nxt = {(r_slot != 2'd1), f_seg7(w_val)};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_slot    <= 2'd0;
      r_act_c   <= 1'b0;
      r_act_d   <= 4'd0;
      r_act_u   <= 4'd0;
      r_act_t   <= 4'd0;
      r_pnd_c   <= 1'b0;
      r_pnd_d   <= 4'd0;
      r_pnd_u   <= 4'd0;
      r_pnd_t   <= 4'd0;
      r_pending <= 1'b0;
      r_seg     <= 8'hFF;
      r_dig     <= 4'hF;
      r_fs      <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) begin
        r_slot <= r_slot + 2'd1;
      end
      r_seg <= w_seg_nxt;
      r_dig <= w_dig_nxt;
      r_fs  <= w_fs_nxt;
      // Active digits only change at the frame boundary; a coincident load bypasses the buffer.
      if (w_boundary) begin
        if (load) begin
          r_act_c   <= centena;
          r_act_d   <= dezena;
          r_act_u   <= unidade;
          r_act_t   <= decimos;
          r_pending <= 1'b0;
        end else if (r_pending) begin
          r_act_c   <= r_pnd_c;
          r_act_d   <= r_pnd_d;
          r_act_u   <= r_pnd_u;
          r_act_t   <= r_pnd_t;
          r_pending <= 1'b0;
        end
      end else if (load) begin
        r_pnd_c   <= centena;
        r_pnd_d   <= dezena;
        r_pnd_u   <= unidade;
        r_pnd_t   <= decimos;
        r_pending <= 1'b1;
      end
    end
  end

  assign seg         = r_seg;
  assign dig         = r_dig;
  assign frame_start = r_fs;
  assign pending     = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_lcd_temp_drv.sv
// ============================================================================
// Module   : tb_lcd_temp_drv
// Purpose  : Directed self-checking bench for lcd_temp_drv (SCAN_DIV=8, BLANK=2)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_temp_drv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       centena = 1'b0;
  logic [3:0] dezena = 4'd0;
  logic [3:0] unidade = 4'd0;
  logic [3:0] decimos = 4'd0;
  logic [7:0] seg;
  logic [3:0] dig;
  logic       frame_start;
  logic       pending;

  int checks = 0;
  int errors = 0;
  int k = 0;

  lcd_temp_drv #(
    .SCAN_DIV    (8),
    .BLANK_CYCLES(2),
    .LZ_BLANK    (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .centena    (centena),
    .dezena     (dezena),
    .unidade    (unidade),
    .decimos    (decimos),
    .seg        (seg),
    .dig        (dig),
    .frame_start(frame_start),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs sampled after tick reflect frame position (k-1) mod 32.
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic int pos();
    return (k - 1) % 32;
  endfunction

  task automatic go_to(input int t);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((pos() != t) && (n < 40));
    if (pos() != t) begin
      checks++;
      errors++;
      $display("FAIL goto_timeout observed=%0d expected=%0d", pos(), t);
    end
  endtask

  task automatic do_load(input logic c, input logic [3:0] d, input logic [3:0] u, input logic [3:0] t);
    centena = c; dezena = d; unidade = u; decimos = t;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Walks the next frame: each slot's blank window, then its mid-slot pattern.
  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] ex [4];
    logic [3:0] dx [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    dx[0] = 4'hE; dx[1] = 4'hD; dx[2] = 4'hB; dx[3] = 4'h7;
    for (int s = 0; s < 4; s++) begin
      go_to(s * 8 + 1);
      chk($sformatf("%s_blank_dig_s%0d", tag, s), {4'h0, dig}, 8'h0F);
      chk($sformatf("%s_blank_seg_s%0d", tag, s), seg, 8'hFF);
      go_to(s * 8 + 5);
      chk($sformatf("%s_seg_s%0d", tag, s), seg, ex[s]);
      chk($sformatf("%s_dig_s%0d", tag, s), {4'h0, dig}, {4'h0, dx[s]});
    end
  endtask

  initial begin
    logic [3:0] exp_dig;
    logic [7:0] exp_seg;
    logic [7:0] zero_seg [4];
    zero_seg[0] = 8'hC0; zero_seg[1] = 8'h40; zero_seg[2] = 8'hFF; zero_seg[3] = 8'hFF;

    // 1. Reset values, then scan sequence for two frames with all-zero data.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", seg, 8'hFF);
    chk("rst_dig", {4'h0, dig}, 8'h0F);
    chk("rst_fs", {7'h0, frame_start}, 8'h00);
    chk("rst_pending", {7'h0, pending}, 8'h00);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      exp_dig = ((pos() % 8) < 2) ? 4'hF : ~(4'b0001 << (pos() / 8));
      exp_seg = ((pos() % 8) < 2) ? 8'hFF : zero_seg[pos() / 8];
      chk($sformatf("scan_dig_p%0d", pos()), {4'h0, dig}, {4'h0, exp_dig});
      chk($sformatf("scan_seg_p%0d", pos()), seg, exp_seg);
      chk($sformatf("scan_fs_p%0d", pos()), {7'h0, frame_start}, {7'h0, (pos() == 0)});
    end

    // 2. Mid-frame load is held back until the frame boundary.
    go_to(10);
    do_load(1'b1, 4'd2, 4'd3, 4'd4);
    chk("l1234_pending", {7'h0, pending}, 8'h01);
    go_to(12);
    chk("l1234_old_s1", seg, 8'h40);
    go_to(20);
    chk("l1234_old_s2", seg, 8'hFF);
    chk("l1234_old_s2_dig", {4'h0, dig}, 8'h0B);
    go_to(28);
    chk("l1234_old_s3", seg, 8'hFF);
    chk("l1234_old_s3_dig", {4'h0, dig}, 8'h07);
    chk("l1234_pending_hold", {7'h0, pending}, 8'h01);
    check_frame("l1234", 8'h99, 8'h30, 8'hA4, 8'hF9);
    chk("l1234_pending_clr", {7'h0, pending}, 8'h00);

    // 3. Leading-zero blanking, then all zeros.
    go_to(29);
    do_load(1'b0, 4'd0, 4'd5, 4'd7);
    chk("l0057_pending", {7'h0, pending}, 8'h01);
    check_frame("l0057", 8'hF8, 8'h12, 8'hFF, 8'hFF);
    do_load(1'b0, 4'd0, 4'd0, 4'd0);
    check_frame("l0000", 8'hC0, 8'h40, 8'hFF, 8'hFF);

    // 4. Non-BCD digits render as dashes; a nonzero dezena is not blanked.
    do_load(1'b0, 4'hA, 4'd3, 4'hF);
    check_frame("dash", 8'hBF, 8'h30, 8'hBF, 8'hFF);

    // 5. Last load wins; a load on the boundary cycle goes straight to active.
    go_to(5);
    do_load(1'b1, 4'd1, 4'd1, 4'd1);
    go_to(15);
    do_load(1'b1, 4'd9, 4'd9, 4'd9);
    go_to(30);
    chk("bnd_pending_before", {7'h0, pending}, 8'h01);
    do_load(1'b0, 4'd4, 4'd2, 4'd0);
    chk("bnd_pending_after", {7'h0, pending}, 8'h00);
    check_frame("bnd", 8'hC0, 8'h24, 8'h99, 8'hFF);
    chk("bnd_pending_end", {7'h0, pending}, 8'h00);

    // 6. Mid-frame reset discards pending data and restarts at slot 0.
    go_to(3);
    do_load(1'b1, 4'd2, 4'd3, 4'd4);
    go_to(20);
    chk("mrst_pending_before", {7'h0, pending}, 8'h01);
    rst = 1'b1;
    #1;
    chk("mrst_seg", seg, 8'hFF);
    chk("mrst_dig", {4'h0, dig}, 8'h0F);
    chk("mrst_pending", {7'h0, pending}, 8'h00);
    tick();
    rst = 1'b0;
    k = 0;
    tick();
    chk("mrst_fs", {7'h0, frame_start}, 8'h01);
    check_frame("mrst", 8'hC0, 8'h40, 8'hFF, 8'hFF);
    chk("mrst_pending_end", {7'h0, pending}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lcd_temp_drv.md
Name: lcd_temp_drv

Overview:
- Drives a 4-digit multiplexed common-anode 7-segment display with a BCD temperature reading in the format C DU.d, range 000.0 to 199.9.
- It is the transmit side of the seg/dig bus that the temperature capture logic decodes. Its output encoding and digit order match that decoder bit for bit.
- It sits between the temperature BCD registers and the display pins.
- New values are double-buffered and applied only at a frame boundary, so a displayed frame never shows mixed old and new digits.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot. Legal range is BLANK_CYCLES+2 or more.
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot, during which all digits are off (anti-ghosting).
- LZ_BLANK, 1: 1 enables leading-zero blanking on centena and dezena.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- load, input, 1: single-cycle strobe that captures the four digit inputs.
- centena, input, 1: hundreds digit (0 or 1).
- dezena, input, 4: tens digit, BCD.
- unidade, input, 4: units digit, BCD.
- decimos, input, 4: tenths digit, BCD.
- seg, output, 8: segments, active-low. seg[6:0] is gfedcba; seg[7] is the decimal point.
- dig, output, 4: digit enables, active-low, one-cold.
- frame_start, output, 1: one-cycle pulse when slot 0 begins.
- pending, output, 1: high while captured data is waiting for the next frame boundary.

Behaviour:
- Reset (async assert; release synchronous to clk):
  - Counters: prescaler cnt=0, slot=0.
  - Digit registers: active and pending all 0.
  - Outputs: pending=0, seg=8'hFF, dig=4'hF, frame_start=0.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, slot advances 0→1→2→3→0.
  - Slot-to-digit mapping:
    - slot 0 = decimos, dig=4'b1110
    - slot 1 = unidade, dig=4'b1101
    - slot 2 = dezena, dig=4'b1011
    - slot 3 = centena, dig=4'b0111
- Outputs are registered: seg, dig and frame_start reflect (slot, cnt) with 1-cycle latency.
- Blanking window:
  - While cnt < BLANK_CYCLES: dig=4'hF and seg=8'hFF.
  - Otherwise: dig takes the slot's one-cold value and seg takes that digit's pattern.
- Segment patterns, seg[6:0] for digits 0–9:
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
- BCD value greater than 9 shows a dash: seg[6:0]=0111111.
- Decimal point: seg[7]=0 only in slot 1 (unidade) outside blanking; otherwise 1.
- Leading-zero blanking (LZ_BLANK=1):
  - centena==0: slot 3 shows seg=8'hFF, and dig stays one-cold as normal.
  - dezena==0 and centena==0: slot 2 is blanked the same way.
  - unidade and decimos are never blanked.
  - LZ_BLANK=0: zeros are displayed.
- Load / double buffer:
  - load=1 captures the inputs into the pending register and sets pending=1.
  - A later load before the boundary overwrites pending data (last value wins).
- Frame boundary (cycle where cnt=SCAN_DIV-1 and slot=3):
  - If pending=1, pending data is copied to active and pending clears.
  - If load=1 in the same cycle, the live inputs go directly to active and pending stays 0.
- frame_start: registered 1-cycle pulse asserted coincident with the first output cycle of slot 0 (cnt=0), once per frame. The first pulse occurs 1 cycle after reset release.
- Reset mid-frame: outputs go to reset values immediately. Pending data is discarded and scanning restarts at slot 0.
- Frame period = 4*SCAN_DIV cycles. Active dig duty per digit = (SCAN_DIV-BLANK_CYCLES)/(4*SCAN_DIV).

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1):
1. Reset held, then released → seg=8'hFF and dig=4'hF during reset. First frame_start 1 cycle after release; pulses repeat every 32 cycles. dig sequence per slot is F,F,E×6, F,F,D×6, F,F,B×6, F,F,7×6.
2. Load 1,2,3,4 (C,D,U,d) mid-frame → current frame still shows 000.0 blanked (slots 3 and 2 blank, slot 1 seg=8'h40, slot 0 seg=8'hC0), pending=1. Next frame: slot 0 seg=8'h99, slot 1 seg=8'h30 (dp on), slot 2 seg=8'hA4, slot 3 seg=8'hF9; pending=0.
3. Load 0,0,5,7 → slots 3 and 2 seg=8'hFF with dig one-cold; slot 1 seg=8'h12; slot 0 seg=8'hF8. Then load 0,0,0,0 → slot 1 seg=8'h40.
4. Load 0,0xA,3,0xF → slot 2 and slot 0 seg[6:0]=0111111 (dash); dezena is not zero, so it is not blanked.
5. Two loads (1,1,1,1 then 1,9,9,9) before the boundary, plus one load (0,4,2,0) exactly at the boundary cycle → next frame shows 042.0 (dezena=4 kept, centena blanked), and pending=0 afterwards.
6. Assert rst for 1 cycle in slot 2 with pending=1 → seg=8'hFF and dig=4'hF immediately. After release, slot 0 restarts, the display shows blanked 000.0 (pending discarded), and pending=0.
